wb2axi4l_bridge: RTL
====================

// Module: wb2axi4l_bridge
// PURPOSE
//  Wishbone classic slave to AXI4-Lite master bridge. Lets Wishbone-based masters
//  (CEP core DMA/test engines, debug hosts) reach AXI4-Lite peripherals on the SoC
//  crossbar. One outstanding transfer at a time; responses are mapped back to ack/err.
// PARAMETERS
//  ADDR_WIDTH  32  address width, both sides
//  DATA_WIDTH  32  data width, both sides; only 32 is supported (sel/strb are 4 bits)
// PORTS
//  wb_clk_i       in   1    single clock for both sides
//  wb_rst_i       in   1    reset, synchronous, active-high
//  wb_adr_i       in   AW   WB address
//  wb_dat_i       in   DW   WB write data
//  wb_sel_i       in   4    WB byte selects
//  wb_we_i        in   1    1=write
//  wb_cyc_i       in   1    WB cycle
//  wb_stb_i       in   1    WB strobe
//  wb_dat_o       out  DW   read data, registered
//  wb_ack_o       out  1    transfer done, OKAY/EXOKAY
//  wb_err_o       out  1    transfer done, SLVERR/DECERR
//  m_axi_awaddr / awprot[3] / awvalid out, awready in
//  m_axi_wdata[DW] / wstrb[4] / wvalid out, wready in
//  m_axi_bresp[2] / bvalid in, bready out
//  m_axi_araddr / arprot[3] / arvalid out, arready in
//  m_axi_rdata[DW] / rresp[2] / rvalid in, rready out
// BEHAVIOUR
//  - All outputs registered or decoded from state. Reset: state IDLE, all valids,
//    bready, rready, ack, err = 0, wb_dat_o = 0, addr/data/strb regs = 0.
//  - FSM: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
//  - IDLE: on cyc&stb latch adr, dat, sel->strb, we; goto WR_REQ (we=1) or RD_REQ.
//  - WR_REQ: awvalid and wvalid rise together next cycle. Each drops independently on
//    its own handshake (aw_done/w_done flags); when both are done -> WR_RESP. Valid
//    is never withdrawn before its ready; addr/data/strb stable while valid.
//  - WR_RESP: bready=1; on bvalid latch err = bresp[1]; -> DONE.
//  - RD_REQ: arvalid=1 until arready -> RD_RESP.
//  - RD_RESP: rready=1; on rvalid latch rdata->wb_dat_o, err = rresp[1]; -> DONE.
//  - DONE: exactly one of ack/err high for one cycle (unless aborted); -> IDLE. The
//    strobe seen in the DONE cycle belongs to the finished transfer and is ignored.
//  - wb_dat_o holds its last read value until the next read completes.
//  - Min latency, ready/valid responses immediate: stb sample -> ack = 4 cycles
//    (IDLE, REQ, RESP, DONE).
//  - awprot/arprot fixed 3'b000. wstrb = wb_sel_i, including 4'b0000, issued as-is.
//  - Abort: cyc drops after IDLE accepts. The AXI transfer still completes per
//    protocol. The abort flag suppresses ack/err in DONE. Read data is still latched.
//  - Early stb drop with cyc held is the same as an abort.
//  - Simultaneous awready and wready in the first cycle -> WR_RESP next cycle.
//  - bvalid before both AW and W handshakes is ignored (bready=0 until WR_RESP).
//  - Reset mid-transfer: immediate return to IDLE, all valids low next cycle. The
//    system resets the AXI slave in the same domain.
// STRUCTURE
//  - wb2axi4l_pkg: state_t enum, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
//  - Single flat module, no sub-module. It pairs with bonfire_axi4l2wb for loopback.
// TESTING
//  1 Write 0xA0 <= 0xDEADBEEF, sel 4'hF, aw/w/b ready=1 -> one AW+W handshake,
//    wstrb=F, ack 1 cycle, 4 cycles after stb.
//  2 Read 0x10, AXI slave rdata=0x12345678 after 3-cycle rvalid delay ->
//    wb_dat_o=0x12345678 with ack.
//  3 Write with awready at +1 but wready at +5 -> awvalid drops at +1, wvalid held
//    to +5, single B, single ack.
//  4 Read with rresp=2'b10 -> err=1, ack=0. Write with bresp=2'b11 -> err=1.
//  5 Read accepted, cyc dropped while RD_RESP -> AXI completes, no ack/err.
//    The next write proceeds normally.
//  6 Assert wb_rst_i during WR_REQ with wvalid high -> all valids 0 next cycle,
//    FSM IDLE, no ack.

Source files
------------

// File: rtl/wb2axi4l_pkg.sv
// Shared state encoding and AXI4-Lite response codes for the Wishbone to
// AXI4-Lite bridge.
package wb2axi4l_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // SLVERR and DECERR surface on Wishbone as err, the OK codes as ack.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic is_err;
        case (resp)
            AXI_RESP_OKAY, AXI_RESP_EXOKAY:   is_err = 1'b0;
            AXI_RESP_SLVERR, AXI_RESP_DECERR: is_err = 1'b1;
            default:                          is_err = 1'b1;
        endcase
        return is_err;
    endfunction

endpackage

// File: rtl/wb2axi4l_bridge.sv
// Wishbone classic slave to AXI4-Lite master bridge, one transfer in flight.
// AXI responses are folded back into a single-cycle ack or err.
module wb2axi4l_bridge
    import wb2axi4l_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    state_t                  state_r;
    state_t                  next_state_s;
    logic [ADDR_WIDTH-1:0]   adr_r;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic [3:0]              strb_r;
    logic                    aw_done_r;
    logic                    aw_done_s;
    logic                    w_done_r;
    logic                    w_done_s;
    logic                    abort_r;
    logic                    err_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic                    req_s;

    assign req_s = wb_cyc_i & wb_stb_i;

    assign m_axi_awaddr  = adr_r;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = (state_r == ST_WR_REQ) && !aw_done_r;
    assign m_axi_wdata   = dat_r;
    assign m_axi_wstrb   = strb_r;
    assign m_axi_wvalid  = (state_r == ST_WR_REQ) && !w_done_r;
    assign m_axi_bready  = (state_r == ST_WR_RESP);
    assign m_axi_araddr  = adr_r;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (state_r == ST_RD_REQ);
    assign m_axi_rready  = (state_r == ST_RD_RESP);

    // An abandoned transfer still finishes on AXI but reports nothing back.
    assign wb_dat_o = rdata_r;
    assign wb_ack_o = (state_r == ST_DONE) && !abort_r && !err_r;
    assign wb_err_o = (state_r == ST_DONE) && !abort_r && err_r;

    // Next-state decode; AW and W complete independently before B is accepted.
    always_comb begin
        next_state_s = state_r;
        aw_done_s    = aw_done_r;
        w_done_s     = w_done_r;
        case (state_r)
            ST_IDLE: begin
                aw_done_s = 1'b0;
                w_done_s  = 1'b0;
                if (req_s) begin
                    next_state_s = wb_we_i ? ST_WR_REQ : ST_RD_REQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                aw_done_s = aw_done_r | m_axi_awready;
                w_done_s  = w_done_r | m_axi_wready;
                if (aw_done_s && w_done_s) begin
                    next_state_s = ST_WR_RESP;
                end else begin
                    next_state_s = ST_WR_REQ;
                end
            end
            ST_WR_RESP: begin
                if (m_axi_bvalid) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WR_RESP;
                end
            end
            ST_RD_REQ: begin
                if (m_axi_arready) begin
                    next_state_s = ST_RD_RESP;
                end else begin
                    next_state_s = ST_RD_REQ;
                end
            end
            ST_RD_RESP: begin
                if (m_axi_rvalid) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RD_RESP;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, request capture, abort tracking and response capture.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r   <= ST_IDLE;
            adr_r     <= {ADDR_WIDTH{1'b0}};
            dat_r     <= {DATA_WIDTH{1'b0}};
            strb_r    <= 4'b0000;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            abort_r   <= 1'b0;
            err_r     <= 1'b0;
            rdata_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r   <= next_state_s;
            aw_done_r <= aw_done_s;
            w_done_r  <= w_done_s;
            if ((state_r == ST_IDLE) && req_s) begin
                adr_r   <= wb_adr_i;
                dat_r   <= wb_dat_i;
                strb_r  <= wb_sel_i;
                abort_r <= 1'b0;
                err_r   <= 1'b0;
            end
            // Losing cyc or stb mid-flight marks the transfer as abandoned.
            if ((state_r inside {ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_RESP}) && !req_s) begin
                abort_r <= 1'b1;
            end
            if ((state_r == ST_WR_RESP) && m_axi_bvalid) begin
                err_r <= resp_is_err(m_axi_bresp);
            end
            if ((state_r == ST_RD_RESP) && m_axi_rvalid) begin
                rdata_r <= m_axi_rdata;
                err_r   <= resp_is_err(m_axi_rresp);
            end
        end
    end

endmodule
